// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the time-of-day core.
//   rtc_state_e      : RUN / LOAD / EDIT / COMMIT controller states
//   FLD_SEC/MIN/HR   : cursor encodings carried on the pos output
//   SEC_MAX/MIN_MAX  : top value of the seconds and minutes fields
package rtc_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LOAD   = 2'd1,
    EDIT   = 2'd2,
    COMMIT = 2'd3
  } rtc_state_e;

  localparam logic [1:0] FLD_SEC = 2'd0;
  localparam logic [1:0] FLD_MIN = 2'd1;
  localparam logic [1:0] FLD_HR  = 2'd2;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides clk by DIV into a single-cycle tick enable.
//   clk, reset : system clock, asynchronous active-high reset
//   hold       : forces the counter to 0 and suppresses tick
//   tick       : high for one cycle when the counter sits at DIV-1
module rtc_prescaler #(
  parameter int DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (hold || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = !hold && (cnt == LAST);

endmodule

// File: rtl/rtc_core.sv
// rtc_core: clk-domain time-of-day counter with a button-driven editor
// and a top-of-hour chime window.
//   clk, reset          : system clock, asynchronous active-high reset
//   set_mod             : level, high requests edit mode
//   left/right          : cursor moves to next higher / lower field
//   up/down             : increment / decrement the field under the cursor
//   hours/minutes/secs  : displayed time (live in RUN, edit copy in EDIT)
//   pos                 : cursor field, 0 = sec, 1 = min, 2 = hr
//   tick                : one-cycle pulse per time increment
//   chime               : high for CHIME_SECS ticks after each hour rollover
// Optional build macro RTC_ALARM_EN adds alarm_en, alarm_hours,
// alarm_minutes and the single-cycle alarm_hit output.
module rtc_core #(
  parameter int CLK_HZ     = 100000000,
  parameter int TICK_HZ    = 1,
  parameter int HOUR_MOD   = 24,
  parameter int CHIME_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_mod,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
`ifdef RTC_ALARM_EN
  input  logic       alarm_en,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  output logic       alarm_hit,
`endif
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] pos,
  output logic       tick,
  output logic       chime
);

  import rtc_pkg::*;

  localparam int         DIV       = CLK_HZ / TICK_HZ;
  localparam logic [4:0] HR_MAX    = 5'(HOUR_MOD - 1);
  localparam logic [5:0] CHIME_LEN = 6'(CHIME_SECS);

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

  rtc_state_e state;
  logic [4:0] live_hr;
  logic [5:0] live_min, live_sec;
  logic [4:0] nxt_hr;
  logic [5:0] nxt_min, nxt_sec;
  logic [5:0] chime_left;

  rtc_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .hold (state != RUN),
    .tick (tick)
  );

  // Live time advanced by one second, with carries.
  always_comb begin
    nxt_sec = wrap_inc(live_sec, SEC_MAX);
    nxt_min = live_min;
    nxt_hr  = live_hr;
    if (live_sec == SEC_MAX) begin
      nxt_min = wrap_inc(live_min, MIN_MAX);
      if (live_min == MIN_MAX)
        nxt_hr = 5'(wrap_inc({1'b0, live_hr}, {1'b0, HR_MAX}));
    end
  end

  // The display registers double as the edit registers: they track live
  // time in RUN and hold the pending edit in EDIT/COMMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      live_hr    <= '0;
      live_min   <= '0;
      live_sec   <= '0;
      hours      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      pos        <= FLD_SEC;
      chime      <= 1'b0;
      chime_left <= '0;
`ifdef RTC_ALARM_EN
      alarm_hit  <= 1'b0;
`endif
    end else begin
`ifdef RTC_ALARM_EN
      alarm_hit <= 1'b0;
`endif
      case (state)
        RUN: begin
          if (tick) begin
            live_hr  <= nxt_hr;
            live_min <= nxt_min;
            live_sec <= nxt_sec;
            hours    <= nxt_hr;
            minutes  <= nxt_min;
            seconds  <= nxt_sec;
            if (nxt_min == 6'd0 && nxt_sec == 6'd0) begin
              chime      <= 1'b1;
              chime_left <= CHIME_LEN;
            end else if (chime) begin
              chime_left <= chime_left - 6'd1;
              if (chime_left == 6'd1)
                chime <= 1'b0;
            end
`ifdef RTC_ALARM_EN
            alarm_hit <= alarm_en && (nxt_hr == alarm_hours) &&
                         (nxt_min == alarm_minutes) && (nxt_sec == 6'd0);
`endif
          end
          if (set_mod)
            state <= LOAD;
        end
        LOAD: begin
          hours      <= live_hr;
          minutes    <= live_min;
          seconds    <= live_sec;
          pos        <= FLD_SEC;
          chime      <= 1'b0;
          chime_left <= '0;
          state      <= EDIT;
        end
        EDIT: begin
          // Adjust uses the cursor position from before any move this cycle.
          if (up != down) begin
            case (pos)
              FLD_SEC: seconds <= up ? wrap_inc(seconds, SEC_MAX) : wrap_dec(seconds, SEC_MAX);
              FLD_MIN: minutes <= up ? wrap_inc(minutes, MIN_MAX) : wrap_dec(minutes, MIN_MAX);
              FLD_HR:  hours   <= 5'(up ? wrap_inc({1'b0, hours}, {1'b0, HR_MAX})
                                        : wrap_dec({1'b0, hours}, {1'b0, HR_MAX}));
              default: ;
            endcase
          end
          if (left && !right)
            pos <= (pos == FLD_HR) ? FLD_SEC : pos + 2'd1;
          else if (right && !left)
            pos <= (pos == FLD_SEC) ? FLD_HR : pos - 2'd1;
          if (!set_mod)
            state <= COMMIT;
        end
        COMMIT: begin
          live_hr  <= hours;
          live_min <= minutes;
          live_sec <= seconds;
          state    <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_core.sv
// tb_rtc_core: drives two rtc_core instances (24 h and 12 h) with the same
// inputs and compares every output each cycle against a model that keeps
// live time as a count of seconds. Alarm ports are exercised when the
// bench is built with RTC_ALARM_EN.
module tb_rtc_core;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int CH      = 3;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int M_RUN = 0, M_LOAD = 1, M_EDIT = 2, M_COMMIT = 3;

  logic clk = 1'b0, reset = 1'b0;
  logic set_mod = 1'b0, left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
  logic       a_en = 1'b0;
  logic [4:0] a_h  = '0;
  logic [5:0] a_m  = '0;

  logic [4:0] hrs[2];
  logic [5:0] mins[2], secs[2];
  logic [1:0] poss[2];
  logic       ticks[2], chimes[2];
`ifdef RTC_ALARM_EN
  logic       ahit[2];
`endif

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  rtc_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MOD(24), .CHIME_SECS(CH)) dut (
    .clk(clk), .reset(reset), .set_mod(set_mod),
    .left(left), .right(right), .up(up), .down(down),
`ifdef RTC_ALARM_EN
    .alarm_en(a_en), .alarm_hours(a_h), .alarm_minutes(a_m), .alarm_hit(ahit[0]),
`endif
    .hours(hrs[0]), .minutes(mins[0]), .seconds(secs[0]), .pos(poss[0]),
    .tick(ticks[0]), .chime(chimes[0])
  );

  rtc_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MOD(12), .CHIME_SECS(CH)) dut12 (
    .clk(clk), .reset(reset), .set_mod(set_mod),
    .left(left), .right(right), .up(up), .down(down),
`ifdef RTC_ALARM_EN
    .alarm_en(a_en), .alarm_hours(a_h), .alarm_minutes(a_m), .alarm_hit(ahit[1]),
`endif
    .hours(hrs[1]), .minutes(mins[1]), .seconds(secs[1]), .pos(poss[1]),
    .tick(ticks[1]), .chime(chimes[1])
  );

  // Reference model: mode, phase within the tick period, live time in
  // seconds since midnight, edit fields, and ticks elapsed in the chime.
  int m_mode, m_phase, m_pos;
  int m_live[2], m_es[2], m_em[2], m_eh[2], m_cht[2];
  bit m_alm[2];

  function automatic int hm(input int k);
    return (k == 0) ? 24 : 12;
  endfunction

  function automatic int step(input int v, input int modulus, input bit inc);
    return inc ? (v + 1) % modulus : (v + modulus - 1) % modulus;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_phase = 0; m_pos = 0;
    for (int k = 0; k < 2; k++) begin
      m_live[k] = 0; m_es[k] = 0; m_em[k] = 0; m_eh[k] = 0; m_cht[k] = -1; m_alm[k] = 0;
    end
  endtask

  task automatic model_step();
    bit t;
    t = (m_mode == M_RUN) && (m_phase == DIV - 1);
    for (int k = 0; k < 2; k++) m_alm[k] = 0;
    case (m_mode)
      M_RUN: begin
        if (t) begin
          for (int k = 0; k < 2; k++) begin
            m_live[k] = (m_live[k] + 1) % (hm(k) * 3600);
            if (m_live[k] % 3600 == 0) m_cht[k] = 0;
            else if (m_cht[k] >= 0) begin
              m_cht[k]++;
              if (m_cht[k] >= CH) m_cht[k] = -1;
            end
            m_alm[k] = a_en && (m_live[k] == int'(a_h) * 3600 + int'(a_m) * 60);
          end
        end
        m_phase = (m_phase + 1) % DIV;
        if (set_mod) m_mode = M_LOAD;
      end
      M_LOAD: begin
        for (int k = 0; k < 2; k++) begin
          m_es[k] = m_live[k] % 60;
          m_em[k] = (m_live[k] / 60) % 60;
          m_eh[k] = m_live[k] / 3600;
          m_cht[k] = -1;
        end
        m_pos = 0; m_phase = 0; m_mode = M_EDIT;
      end
      M_EDIT: begin
        if (up != down) begin
          for (int k = 0; k < 2; k++) begin
            case (m_pos)
              0: m_es[k] = step(m_es[k], 60, up);
              1: m_em[k] = step(m_em[k], 60, up);
              2: m_eh[k] = step(m_eh[k], hm(k), up);
              default: ;
            endcase
          end
        end
        if (left && !right) m_pos = (m_pos + 1) % 3;
        else if (right && !left) m_pos = (m_pos + 2) % 3;
        if (!set_mod) m_mode = M_COMMIT;
      end
      default: begin
        for (int k = 0; k < 2; k++) m_live[k] = m_eh[k] * 3600 + m_em[k] * 60 + m_es[k];
        m_mode = M_RUN; m_phase = 0;
      end
    endcase
  endtask

  task automatic check_all();
    int eh, em, es;
    for (int k = 0; k < 2; k++) begin
      if (m_mode == M_EDIT || m_mode == M_COMMIT) begin
        eh = m_eh[k]; em = m_em[k]; es = m_es[k];
      end else begin
        eh = m_live[k] / 3600; em = (m_live[k] / 60) % 60; es = m_live[k] % 60;
      end
      chk($sformatf("hours[%0d]", k), int'(hrs[k]), eh);
      chk($sformatf("minutes[%0d]", k), int'(mins[k]), em);
      chk($sformatf("seconds[%0d]", k), int'(secs[k]), es);
      chk($sformatf("pos[%0d]", k), int'(poss[k]), m_pos);
      chk($sformatf("tick[%0d]", k), int'(ticks[k]),
          (m_mode == M_RUN && m_phase == DIV - 1) ? 1 : 0);
      chk($sformatf("chime[%0d]", k), int'(chimes[k]), (m_cht[k] >= 0) ? 1 : 0);
`ifdef RTC_ALARM_EN
      chk($sformatf("alarm_hit[%0d]", k), int'(ahit[k]), int'(m_alm[k]));
`endif
    end
  endtask

  // One clock: DUT and model both consume the inputs present at the edge,
  // outputs are compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_mod = 1'b0; left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic press(input logic l, input logic r, input logic u, input logic d);
    left = l; right = r; up = u; down = d;
    cycle();
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
  endtask

  typedef struct {
    int sm, l, r, u, d;
    int eh, eh12, em, es, ep;
  } vec_t;
  vec_t tbl[19];

  initial begin
    int first, ntk, nhit, hit_at, prev, chc0, chc1, n;

    // Edit walk from 00:00:00; expected display after each edge.
    //             sm l  r  u  d   hr h12 min sec pos
    tbl[0]  = '{1, 0, 0, 0, 0,  0, 0,  0, 0, 0};  // -> LOAD
    tbl[1]  = '{1, 0, 0, 0, 0,  0, 0,  0, 0, 0};  // -> EDIT
    tbl[2]  = '{1, 0, 0, 1, 0,  0, 0,  0, 1, 0};
    tbl[3]  = '{1, 0, 0, 1, 0,  0, 0,  0, 2, 0};
    tbl[4]  = '{1, 0, 0, 1, 0,  0, 0,  0, 3, 0};
    tbl[5]  = '{1, 1, 0, 0, 0,  0, 0,  0, 3, 1};
    tbl[6]  = '{1, 0, 0, 0, 1,  0, 0, 59, 3, 1};  // min 0 -> 59
    tbl[7]  = '{1, 1, 1, 0, 0,  0, 0, 59, 3, 1};  // left+right: no move
    tbl[8]  = '{1, 0, 0, 1, 1,  0, 0, 59, 3, 1};  // up+down: no change
    tbl[9]  = '{1, 1, 0, 1, 0,  0, 0,  0, 3, 2};  // adjust old pos, then move
    tbl[10] = '{1, 0, 0, 0, 1, 23, 11,  0, 3, 2};  // hr 0 -> max
    tbl[11] = '{1, 0, 0, 1, 0,  0, 0,  0, 3, 2};
    tbl[12] = '{1, 0, 1, 0, 0,  0, 0,  0, 3, 1};
    tbl[13] = '{1, 0, 0, 0, 1,  0, 0, 59, 3, 1};
    tbl[14] = '{1, 0, 1, 0, 0,  0, 0, 59, 3, 0};
    tbl[15] = '{1, 0, 1, 0, 0,  0, 0, 59, 3, 2};  // right wraps 0 -> 2
    tbl[16] = '{1, 1, 0, 0, 0,  0, 0, 59, 3, 0};  // left wraps 2 -> 0
    tbl[17] = '{0, 0, 0, 0, 0,  0, 0, 59, 3, 0};  // -> COMMIT
    tbl[18] = '{0, 0, 0, 0, 0,  0, 0, 59, 3, 0};  // -> RUN

    model_reset();
    #2;
    do_reset();

    // Free run from reset: tick is high during the 10th clock period after
    // release (sampled after edge 9); 60 ticks reach 00:01:00.
    a_en = 1'b1; a_h = 5'd0; a_m = 6'd1;
    first = -1; ntk = 0; nhit = 0; hit_at = -1;
    for (int i = 1; i <= 610; i++) begin
      cycle();
      if (ticks[0]) begin
        ntk++;
        if (first < 0) first = i;
      end
`ifdef RTC_ALARM_EN
      if (ahit[0]) begin nhit++; hit_at = i; end
`endif
      if (i == 600) begin
        chk("ticks_to_1min", ntk, 60);
        chk("run_hr", int'(hrs[0]), 0);
        chk("run_min", int'(mins[0]), 1);
        chk("run_sec", int'(secs[0]), 0);
      end
    end
    chk("first_tick", first, 9);
`ifdef RTC_ALARM_EN
    chk("alarm_pulses", nhit, 1);
    chk("alarm_at_60th_tick", hit_at, 600);
    do_reset();
    a_en = 1'b0;
    nhit = 0;
    for (int i = 1; i <= 610; i++) begin
      cycle();
      if (ahit[0] || ahit[1]) nhit++;
    end
    chk("alarm_disabled_pulses", nhit, 0);
`endif
    a_en = 1'b0;

    // Table-driven edit walk.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      set_mod = (tbl[i].sm != 0); left = (tbl[i].l != 0); right = (tbl[i].r != 0);
      up = (tbl[i].u != 0); down = (tbl[i].d != 0);
      cycle();
      chk($sformatf("vec%0d_hr24", i), int'(hrs[0]), tbl[i].eh);
      chk($sformatf("vec%0d_hr12", i), int'(hrs[1]), tbl[i].eh12);
      chk($sformatf("vec%0d_min", i), int'(mins[0]), tbl[i].em);
      chk($sformatf("vec%0d_sec", i), int'(secs[0]), tbl[i].es);
      chk($sformatf("vec%0d_pos", i), int'(poss[0]), tbl[i].ep);
    end
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    // COMMIT was the cycle after edge 17; the tick follows DIV cycles later.
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (ticks[0] && first < 0) first = i;
    end
    chk("commit_first_tick", first, 9);
    chk("commit_sec_after_tick", int'(secs[0]), 4);

    // Edit to 23:59:58 (11:59:58 on the 12 h unit), run through the hour.
    do_reset();
    set_mod = 1'b1;
    cycle(); cycle();
    press(0, 1, 0, 0); press(0, 0, 0, 1);
    press(0, 1, 0, 0); press(0, 0, 0, 1);
    press(0, 1, 0, 0); press(0, 0, 0, 1); press(0, 0, 0, 1);
    set_mod = 1'b0;
    cycle(); cycle();
    chk("preset_hr24", int'(hrs[0]), 23);
    chk("preset_hr12", int'(hrs[1]), 11);
    chk("preset_min", int'(mins[0]), 59);
    chk("preset_sec", int'(secs[0]), 58);
    prev = -1; ntk = 0; chc0 = 0; chc1 = 0;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (ticks[0]) begin
        chk("tick_gap", i - prev, 10);
        prev = i; ntk++;
      end
      if (chimes[0]) chc0++;
      if (chimes[1]) chc1++;
      if (i == 20) begin
        chk("rollover_hr24", int'(hrs[0]), 0);
        chk("rollover_hr12", int'(hrs[1]), 0);
        chk("rollover_min", int'(mins[0]), 0);
        chk("rollover_sec", int'(secs[0]), 0);
        chk("chime_start", int'(chimes[0]), 1);
      end
    end
    chk("chime_cycles24", chc0, CH * DIV);
    chk("chime_cycles12", chc1, CH * DIV);
    chk("ticks_in_60", ntk, 6);

    // Reset in the middle of an edit discards it.
    set_mod = 1'b1;
    cycle(); cycle();
    press(0, 0, 1, 0); press(1, 0, 0, 0); press(0, 0, 1, 0);
    do_reset();
    chk("rst_sec", int'(secs[0]), 0);
    chk("rst_min", int'(mins[0]), 0);
    chk("rst_pos", int'(poss[0]), 0);
    for (int i = 1; i <= 10; i++) cycle();
    chk("rst_then_run_sec", int'(secs[0]), 1);
    chk("rst_then_run_min", int'(mins[0]), 0);

    // Randomized run / edit sessions with stray button pulses.
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 1) == 1) begin
        a_en = 1'b1;
        n = (m_live[0] / 60 + 1) % 1440;
        a_h = 5'(n / 60); a_m = 6'(n % 60);
      end else begin
        a_en = 1'($urandom_range(0, 1));
        a_h = 5'($urandom_range(0, 23)); a_m = 6'($urandom_range(0, 59));
      end
      if ($urandom_range(0, 1) == 1) begin
        set_mod = 1'b0;
        n = $urandom_range(1, 700);
        for (int i = 0; i < n; i++) begin
          left = ($urandom_range(0, 7) == 0); right = ($urandom_range(0, 7) == 0);
          up = ($urandom_range(0, 7) == 0); down = ($urandom_range(0, 7) == 0);
          cycle();
        end
      end else begin
        set_mod = 1'b1;
        n = $urandom_range(3, 40);
        for (int i = 0; i < n; i++) begin
          left = ($urandom_range(0, 3) == 0); right = ($urandom_range(0, 3) == 0);
          up = ($urandom_range(0, 2) == 0); down = ($urandom_range(0, 2) == 0);
          cycle();
        end
      end
    end
    set_mod = 1'b0; left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    for (int i = 0; i < 20; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_core.md
Name: rtc_core

Overview:
Parametrised time-of-day core that replaces the fixed 1 Hz toggled-clock timer and setter pair with a single clk-domain block.
- Prescaler produces a single-cycle tick enable; no derived clocks.
- Edit-mode state machine: cursor field selection, wrap-around adjust, atomic commit.
- Top-of-hour chime window for the audio player.
- Sits between the button debouncers and the seven-segment display driver.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz.
TICK_HZ, 1, time-base ticks per displayed second; set >1 only for accelerated demo or sim; must divide CLK_HZ.
HOUR_MOD, 24, hour counter modulus (24 or 12; in 12 mode hours run 0..11).
CHIME_SECS, 10, chime length in ticks after each hour rollover; range 1..59.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
set_mod  in  1  level; high = edit mode.
left  in  1  debounced single-cycle pulse; cursor to next higher field.
right  in  1  debounced single-cycle pulse; cursor to next lower field.
up  in  1  debounced pulse; increment selected field.
down  in  1  debounced pulse; decrement selected field.
hours  out  5  displayed hours (live in RUN, edit copy in EDIT).
minutes  out  6  displayed minutes.
seconds  out  6  displayed seconds.
pos  out  2  cursor: 0 = sec, 1 = min, 2 = hr.
tick  out  1  single-cycle pulse per time increment.
chime  out  1  level; high during the chime window.

Behaviour:
Reset:
- All time and edit registers 0; pos = 0; tick = 0; chime = 0; state RUN; prescaler = 0.
- A reset during EDIT discards all edits.

Prescaler:
- DIV = CLK_HZ/TICK_HZ; counter runs 0..DIV-1.
- tick is high in the cycle the counter equals DIV-1 and the state is RUN; counter then wraps to 0.
- Counter is held at 0 in LOAD, EDIT and COMMIT.
- After COMMIT, the first tick comes exactly DIV cycles later.

Time increment (on tick):
- sec 59 -> 0 with carry to min.
- min 59 -> 0 with carry to hr.
- hr HOUR_MOD-1 -> 0.
- All binary; no BCD.

State machine:
- RUN: if set_mod is sampled high -> LOAD. A tick in that same cycle is applied first.
- LOAD (1 cycle): copy live time into edit registers; pos <= 0; chime <= 0. Always -> EDIT.
- EDIT: set_mod low -> COMMIT.
  - left: pos 0 -> 1 -> 2 -> 0.
  - right: pos 0 -> 2 -> 1 -> 0.
  - up/down: modular ±1 on the selected field.
    - sec/min: 59 <-> 0.
    - hr: HOUR_MOD-1 <-> 0.
    - No carry between fields.
- COMMIT (1 cycle): edit registers -> live time. -> RUN.

Simultaneous events:
- up and down in the same cycle: no change.
- left and right in the same cycle: pos unchanged.
- Cursor move and value adjust in the same cycle: adjust applies to the old pos.
- Button pulses are ignored outside EDIT.

Chime:
- Set high in the cycle after a tick that produces min = 0, sec = 0.
- Cleared after CHIME_SECS further ticks.
- Cleared on entry to LOAD.
- A commit to xx:00:00 does not start a chime.

Outputs:
- hours, minutes, seconds, pos and chime are registered.
- Displayed time changes the cycle after the causing event.

Optional Feature:
Macro RTC_ALARM_EN.
With the macro defined:
- Adds inputs alarm_en (1), alarm_hours (5) and alarm_minutes (6), and output alarm_hit (1).
- alarm_hit is a single-cycle registered pulse, the cycle after a tick that produces time equal to alarm_hours:alarm_minutes:00, when alarm_en = 1.
- Never fires from COMMIT.
- Reset value 0.

Without the macro: these ports and their logic are absent.

Decomposition:
- Package rtc_pkg holds:
  - state enum RUN/LOAD/EDIT/COMMIT;
  - field constants FLD_SEC = 0, FLD_MIN = 1, FLD_HR = 2;
  - SEC_MAX = 59, MIN_MAX = 59.
- One sub-module, rtc_prescaler (DIV counter, hold input, tick output).

Test Plan:
- CLK_HZ = 10, TICK_HZ = 1: release reset, run 600 cycles -> first tick at cycle 10; 00:01:00 after 60 ticks.
- Edit to 23:59:58 with CHIME_SECS = 3, then run -> 2 ticks give 00:00:00; chime high for exactly 3 ticks; tick cadence 10 cycles.
- set_mod high; up ×3 at pos 0; left; down at min 0; release -> display 00:59:03 in EDIT; committed after COMMIT; first tick exactly 10 cycles after COMMIT.
- In EDIT, up+down together and left+right together -> values and pos unchanged; down at hr 0 with HOUR_MOD = 12 -> 11.
- Reset asserted mid-EDIT with edits pending -> all outputs 0, state RUN, edits lost.
- RTC_ALARM_EN, alarm 00:01, alarm_en = 1, start 00:00:00 -> one alarm_hit pulse on the 60th tick; alarm_en = 0 -> no pulse.
